// File: rtl/riscv_nn_regfile_sb.sv
// riscv_nn_regfile_sb
// Flip-flop register file with N read / M write ports, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard that tracks
// long-latency (MAC/LSU) writebacks. The integer bank always exists; the FP
// bank is added above it (index bit 5) only when FPU=1 and ZFINX=0.
module riscv_nn_regfile_sb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 3,
    parameter int N_WRITE    = 2,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int BYPASS     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  test_en_i,
    input  logic [N_READ-1:0][ADDR_WIDTH-1:0]     raddr_i,
    output logic [N_READ-1:0][DATA_WIDTH-1:0]     rdata_o,
    output logic [N_READ-1:0]                     rbusy_o,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    waddr_i,
    input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [N_WRITE-1:0]                    we_i,
    input  logic                                  alloc_valid_i,
    input  logic [ADDR_WIDTH-1:0]                 alloc_addr_i,
    output logic                                  alloc_ready_o,
    output logic [6:0]                            pending_cnt_o
);

    // With an FP bank the flat index is {bank, reg}; without one, bit 5 is
    // simply dropped so FP addresses alias the integer bank.
    localparam bit HAS_FP = (FPU != 0) && (ZFINX == 0);
    localparam int IDX_W  = HAS_FP ? 6 : 5;
    localparam int NREGS  = 1 << IDX_W;
    localparam bit BYP    = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]      busy_reg;
    logic [NREGS-1:0]      busy_next;
    logic [6:0]            cnt_reg;
    logic [6:0]            cnt_next;

    // Per-register write decode: hit flag plus data of the winning port.
    logic [NREGS-1:0]      wr_hit;
    logic [DATA_WIDTH-1:0] wr_data [NREGS];

    logic [IDX_W-1:0]      alloc_idx;
    logic                  alloc_fire;

    // Address bits not used by the selected bank layout, and test_en_i.
    logic unused_bits;
    assign unused_bits = ^{test_en_i, alloc_addr_i, raddr_i, waddr_i};

    // Decode write ports; ascending loop lets the highest index win, x0 dropped.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r]  = 1'b0;
            wr_data[r] = '0;
        end
        for (int p = 0; p < N_WRITE; p++) begin
            if (we_i[p] && (waddr_i[p][IDX_W-1:0] != '0)) begin
                wr_hit[waddr_i[p][IDX_W-1:0]]  = 1'b1;
                wr_data[waddr_i[p][IDX_W-1:0]] = wdata_i[p];
            end
        end
    end

    // An allocation is accepted when the target is idle or being written now;
    // x0 is always accepted but never becomes busy.
    assign alloc_idx     = alloc_addr_i[IDX_W-1:0];
    assign alloc_ready_o = (alloc_idx == '0) | ~busy_reg[alloc_idx] | wr_hit[alloc_idx];
    assign alloc_fire    = alloc_valid_i & alloc_ready_o & (alloc_idx != '0);

    // Next busy vector and pending count; an allocation beats a same-edge write.
    always_comb begin
        busy_next = busy_reg & ~wr_hit;
        cnt_next  = cnt_reg;
        for (int r = 0; r < NREGS; r++) begin
            if (busy_reg[r] && wr_hit[r] && !(alloc_fire && (alloc_idx == IDX_W'(r)))) begin
                cnt_next = cnt_next - 7'd1;
            end
        end
        if (alloc_fire) begin
            if (!busy_reg[alloc_idx]) begin
                cnt_next = cnt_next + 7'd1;
            end
            busy_next[alloc_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Register storage; x0 is cleared by reset and never written afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs_reg[r] <= wr_data[r];
                end
            end
        end
    end

    // Scoreboard state: busy bits and the running count of busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign pending_cnt_o = cnt_reg;

    // Combinational read ports with optional same-cycle forwarding.
    for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
        logic [IDX_W-1:0] ridx;
        assign ridx        = raddr_i[gi][IDX_W-1:0];
        assign rdata_o[gi] = (BYP && wr_hit[ridx]) ? wr_data[ridx] : regs_reg[ridx];
        assign rbusy_o[gi] = busy_reg[ridx] & ~(BYP & wr_hit[ridx]);
    end

endmodule

// File: tb/tb_riscv_nn_regfile_sb.sv
// tb_riscv_nn_regfile_sb
// Four configurations share one stimulus stream:
//   unit 0: default (BYPASS=1, integer bank only)
//   unit 1: BYPASS=0
//   unit 2: FPU=1, separate FP bank
//   unit 3: FPU=1, ZFINX=1 (FP aliases the integer bank)
// Stimulus pushes expected outputs into a queue; a monitor on the falling
// edge pops every queued expectation and compares it with the live outputs.
module tb_riscv_nn_regfile_sb;

    logic clk;
    logic rst_n;
    logic test_en;
    logic [2:0][5:0]  raddr;
    logic [1:0][5:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0]       we;
    logic             alloc_valid;
    logic [5:0]       alloc_addr;

    logic [2:0][31:0] rdata_d [4];
    logic [2:0]       rbusy_d [4];
    logic             ready_d [4];
    logic [6:0]       cnt_d   [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          unit;
        int          kind;   // 0 rdata, 1 rbusy, 2 alloc_ready, 3 pending_cnt
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        riscv_nn_regfile_sb #(
            .ADDR_WIDTH(6),
            .DATA_WIDTH(32),
            .N_READ(3),
            .N_WRITE(2),
            .FPU((gi >= 2) ? 1 : 0),
            .ZFINX((gi == 3) ? 1 : 0),
            .BYPASS((gi == 1) ? 0 : 1)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .test_en_i(test_en),
            .raddr_i(raddr),
            .rdata_o(rdata_d[gi]),
            .rbusy_o(rbusy_d[gi]),
            .waddr_i(waddr),
            .wdata_i(wdata),
            .we_i(we),
            .alloc_valid_i(alloc_valid),
            .alloc_addr_i(alloc_addr),
            .alloc_ready_o(ready_d[gi]),
            .pending_cnt_o(cnt_d[gi])
        );
    end

    function automatic logic [31:0] actual(input int u, input int k, input int p);
        case (k)
            0:       return rdata_d[u][p];
            1:       return {31'b0, rbusy_d[u][p]};
            2:       return {31'b0, ready_d[u]};
            default: return {25'b0, cnt_d[u]};
        endcase
    endfunction

    // Monitor: drain all expectations queued for this cycle.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = actual(mon_e.unit, mon_e.kind, mon_e.port);
            checks++;
            if (mon_act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s unit%0d port%0d: got %h, expected %h",
                         mon_e.name, mon_e.unit, mon_e.port, mon_act, mon_e.exp);
            end else begin
                $display("ok   %s unit%0d port%0d: %h", mon_e.name, mon_e.unit, mon_e.port, mon_act);
            end
        end
    end

    task automatic push(input int u, input int k, input int p, input logic [31:0] v, input string n);
        exp_t e;
        e.unit = u; e.kind = k; e.port = p; e.exp = v; e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic exp_rd(input int u, input int p, input logic [31:0] v, input string n);
        push(u, 0, p, v, n);
    endtask

    task automatic exp_bz(input int u, input int p, input logic v, input string n);
        push(u, 1, p, {31'b0, v}, n);
    endtask

    task automatic exp_rdy(input int u, input logic v, input string n);
        push(u, 2, 0, {31'b0, v}, n);
    endtask

    task automatic exp_cnt(input int u, input int v, input string n);
        push(u, 3, 0, 32'(v), n);
    endtask

    // Advance one cycle and return inputs to idle just after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        we          = '0;
        waddr       = '0;
        wdata       = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        raddr       = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        test_en     = 1'b0;
        we          = '0;
        waddr       = '0;
        wdata       = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        raddr       = '0;

        // Reset state: every register reads 0 on every port.
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            raddr = {6'(a), 6'(a), 6'(a)};
            for (int p = 0; p < 3; p++) begin
                exp_rd(0, p, 32'h0, "reset_rd");
                exp_bz(0, p, 1'b0, "reset_busy");
            end
            if (a == 0) begin
                for (int u = 0; u < 4; u++) begin
                    exp_rdy(u, 1'b1, "reset_ready");
                    exp_cnt(u, 0, "reset_cnt");
                end
            end
        end
        next_cycle();
        rst_n = 1'b1;

        // Both ports write x5 together: port 1 wins.
        next_cycle();
        we = 2'b11; waddr = {6'd5, 6'd5}; wdata = {32'h12345678, 32'hDEADBEEF};
        raddr[0] = 6'd5;
        exp_rd(0, 0, 32'h12345678, "prio_bypass");
        exp_rd(1, 0, 32'h00000000, "prio_nobypass_old");
        // Write to x0 is dropped, also on the bypass path.
        next_cycle();
        we = 2'b01; waddr[0] = 6'd0; wdata[0] = 32'hFFFFFFFF;
        raddr[0] = 6'd5; raddr[1] = 6'd0;
        exp_rd(0, 0, 32'h12345678, "prio_result");
        exp_rd(1, 0, 32'h12345678, "prio_result");
        exp_rd(0, 1, 32'h0, "x0_bypass");
        exp_rd(1, 1, 32'h0, "x0_bypass");
        next_cycle();
        raddr[1] = 6'd0;
        exp_rd(0, 1, 32'h0, "x0_stays0");
        exp_rd(1, 1, 32'h0, "x0_stays0");

        // Same-cycle bypass vs. registered read.
        next_cycle();
        we = 2'b01; waddr[0] = 6'd7; wdata[0] = 32'hA5A5A5A5;
        raddr[2] = 6'd7;
        exp_rd(0, 2, 32'hA5A5A5A5, "bypass_now");
        exp_rd(1, 2, 32'h00000000, "nobypass_old");
        next_cycle();
        raddr[2] = 6'd7;
        exp_rd(0, 2, 32'hA5A5A5A5, "bypass_next");
        exp_rd(1, 2, 32'hA5A5A5A5, "nobypass_next");

        // Scoreboard: allocate x9.
        next_cycle();
        alloc_valid = 1'b1; alloc_addr = 6'd9; raddr[0] = 6'd9;
        exp_rdy(0, 1'b1, "alloc_ready_idle");
        exp_bz(0, 0, 1'b0, "busy_before");
        exp_cnt(0, 0, "cnt_before");
        // Re-allocate x9 is refused.
        next_cycle();
        alloc_valid = 1'b1; alloc_addr = 6'd9; raddr[0] = 6'd9;
        exp_rdy(0, 1'b0, "realloc_ready");
        exp_rdy(1, 1'b0, "realloc_ready");
        exp_bz(0, 0, 1'b1, "busy_set");
        exp_cnt(0, 1, "cnt_one");
        // Writeback x9=3: ready again, bypass masks rbusy.
        next_cycle();
        we = 2'b01; waddr[0] = 6'd9; wdata[0] = 32'd3;
        alloc_addr = 6'd9; raddr[0] = 6'd9;
        exp_rdy(0, 1'b1, "ready_on_write");
        exp_bz(0, 0, 1'b0, "rbusy_bypass");
        exp_bz(1, 0, 1'b1, "rbusy_nobypass");
        exp_cnt(0, 1, "cnt_still1");
        next_cycle();
        raddr[0] = 6'd9;
        exp_bz(0, 0, 1'b0, "busy_cleared");
        exp_bz(1, 0, 1'b0, "busy_cleared");
        exp_cnt(0, 0, "cnt_zero");
        exp_rd(1, 0, 32'd3, "wb_data");
        // Alloc and write x9 on the same edge: allocation wins.
        next_cycle();
        we = 2'b10; waddr[1] = 6'd9; wdata[1] = 32'd3;
        alloc_valid = 1'b1; alloc_addr = 6'd9;
        exp_rdy(0, 1'b1, "alloc_write_ready");
        next_cycle();
        raddr[0] = 6'd9;
        exp_bz(0, 0, 1'b1, "alloc_wins_busy");
        exp_bz(1, 0, 1'b1, "alloc_wins_busy");
        exp_cnt(0, 1, "alloc_wins_cnt");
        exp_rd(0, 0, 32'd3, "alloc_wins_data");
        // Allocating x0: accepted, no effect.
        next_cycle();
        alloc_valid = 1'b1; alloc_addr = 6'd0;
        exp_rdy(0, 1'b1, "x0_alloc_ready");
        next_cycle();
        raddr[1] = 6'd0;
        exp_cnt(0, 1, "x0_alloc_cnt");
        exp_bz(0, 1, 1'b0, "x0_never_busy");

        // FP bank: 0x21 is f1 with FPU, aliases x1 otherwise.
        next_cycle();
        we = 2'b01; waddr[0] = 6'h21; wdata[0] = 32'h3F800000;
        raddr[0] = 6'h21; raddr[1] = 6'd1;
        exp_rd(2, 0, 32'h3F800000, "fp_bypass");
        exp_rd(2, 1, 32'h00000000, "fp_x1_untouched");
        exp_rd(3, 1, 32'h3F800000, "zfinx_x1_bypass");
        next_cycle();
        raddr[0] = 6'h21; raddr[1] = 6'd1;
        exp_rd(2, 0, 32'h3F800000, "fp_f1");
        exp_rd(2, 1, 32'h00000000, "fp_x1_stays0");
        exp_rd(3, 1, 32'h3F800000, "zfinx_x1");
        exp_rd(1, 1, 32'h3F800000, "nofp_alias_x1");
        // f0 is an ordinary register; without an FP bank it aliases x0.
        next_cycle();
        we = 2'b01; waddr[0] = 6'h20; wdata[0] = 32'h11111111;
        next_cycle();
        raddr[0] = 6'h20; raddr[1] = 6'd0;
        exp_rd(2, 0, 32'h11111111, "fp_f0_normal");
        exp_rd(2, 1, 32'h00000000, "fp_x0_zero");
        exp_rd(3, 0, 32'h00000000, "zfinx_f0_is_x0");

        // Build up four busy registers: x9 plus x10..x12.
        for (int a = 10; a < 13; a++) begin
            next_cycle();
            alloc_valid = 1'b1; alloc_addr = 6'(a);
            exp_rdy(0, 1'b1, "alloc_more");
        end
        next_cycle();
        raddr = {6'd11, 6'd10, 6'd9};
        exp_cnt(0, 4, "cnt_four");
        exp_cnt(2, 4, "cnt_four");
        for (int p = 0; p < 3; p++) exp_bz(0, p, 1'b1, "busy_four");

        // Asynchronous reset mid-stream clears everything at once.
        next_cycle();
        rst_n = 1'b0;
        raddr = {6'd9, 6'd7, 6'd5};
        alloc_addr = 6'd12;
        for (int p = 0; p < 3; p++) begin
            exp_rd(0, p, 32'h0, "midrst_rd");
            exp_bz(0, p, 1'b0, "midrst_busy");
        end
        exp_cnt(0, 0, "midrst_cnt");
        exp_rdy(0, 1'b1, "midrst_ready");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        raddr = {6'd9, 6'd7, 6'd5};
        exp_rd(0, 0, 32'h0, "postrst_x5");
        exp_rd(1, 2, 32'h0, "postrst_x9");
        exp_cnt(0, 0, "postrst_cnt");

        next_cycle();
        next_cycle();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
